rggen_host_arbiter: RTL and testbench

- Shares a single register-block host bus between NUM_HOSTS independent requesters using round-robin arbitration.
- The shared bus carries request, address, write, write data, ready, read data and status.
- Sits between multiple bus bridges (e.g. CPU bridge and debug bridge) and the register block's address-decode front end, upstream of all default and indirect registers.
- Provides an optional access timeout so a host is never hung by an unanswered access.

---
 rtl/rggen_host_arbiter.sv | 153 +++++++++++++++
 tb/tb_rggen_host_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rggen_host_arbiter.sv
// Round-robin arbiter sharing one register-block host bus between several
// requesting bridges. One access is in flight at a time; an optional timeout
// terminates an access the downstream side never answers.
module rggen_host_arbiter #(
    parameter int NUM_HOSTS      = 2,
    parameter int ADDRESS_WIDTH  = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_HOSTS-1:0]              i_request,
    input  logic [NUM_HOSTS*ADDRESS_WIDTH-1:0] i_address,
    input  logic [NUM_HOSTS-1:0]              i_write,
    input  logic [NUM_HOSTS*DATA_WIDTH-1:0]   i_write_data,
    output logic [NUM_HOSTS-1:0]              o_ready,
    output logic [DATA_WIDTH-1:0]             o_read_data,
    output logic [1:0]                        o_status,
    output logic                              o_request,
    output logic [ADDRESS_WIDTH-1:0]          o_address,
    output logic                              o_write,
    output logic [DATA_WIDTH-1:0]             o_write_data,
    input  logic                              i_ready,
    input  logic [DATA_WIDTH-1:0]             i_read_data,
    input  logic [1:0]                        i_status
);

    localparam int GW = (NUM_HOSTS > 1) ? $clog2(NUM_HOSTS) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [GW-1:0] LAST_HOST  = GW'(NUM_HOSTS - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [1:0]    STATUS_SLVERR = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   ptr_q, ptr_d;
    logic [TW-1:0]   timer_q, timer_d;

    logic            any_request;
    logic [GW-1:0]   rr_pick;
    logic            timeout_hit;
    logic            complete;

    // Round-robin pick: first requester above the pointer, else first at or below it.
    always_comb begin
        logic            found_hi;
        logic            found_lo;
        logic [GW-1:0]   pick_hi;
        logic [GW-1:0]   pick_lo;
        // NOTE: every combinational output gets a default before any branch so no latch is inferred.
        found_hi    = 1'b0;
        found_lo    = 1'b0;
        pick_hi     = '0;
        pick_lo     = '0;
        for (int j = 0; j < NUM_HOSTS; j++) begin
            if (!found_hi && i_request[j] && (GW'(j) > ptr_q)) begin
                found_hi = 1'b1;
                pick_hi  = GW'(j);
            end
            if (!found_lo && i_request[j] && (GW'(j) <= ptr_q)) begin
                found_lo = 1'b1;
                pick_lo  = GW'(j);
            end
        end
        any_request = found_hi || found_lo;
        rr_pick     = found_hi ? pick_hi : pick_lo;
    end

    // Timeout fires on the last allowed BUSY cycle; a same-cycle i_ready wins.
    assign timeout_hit = (TIMEOUT_CYCLES > 0) && (state_q == BUSY) && !i_ready
                         && (timer_q == TIMER_LAST);
    assign complete    = (state_q == BUSY) && (i_ready || timeout_hit);

    // State register: arbitration state, grant, last-grant pointer and timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= LAST_HOST;
            timer_q <= '0;
        end else begin
            // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            timer_q <= timer_d;
        end
    end

    // Next-state logic: grant in IDLE, wait for completion or timeout in BUSY.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        timer_d = timer_q;
        case (state_q)
            IDLE: begin
                if (any_request) begin
                    state_d = BUSY;
                    grant_d = rr_pick;
                    timer_d = '0;
                end
            end
            BUSY: begin
                if (complete) begin
                    state_d = IDLE;
                    ptr_d   = grant_q;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: downstream mux while BUSY, completion response to the granted host.
    always_comb begin
        o_request    = 1'b0;
        o_address    = '0;
        o_write      = 1'b0;
        o_write_data = '0;
        o_ready      = '0;
        o_read_data  = '0;
        o_status     = 2'b00;
        if (state_q == BUSY) begin
            o_request = 1'b1;
            for (int j = 0; j < NUM_HOSTS; j++) begin
                if (grant_q == GW'(j)) begin
                    o_address    = i_address[j*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                    o_write      = i_write[j];
                    o_write_data = i_write_data[j*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
        if (complete) begin
            for (int j = 0; j < NUM_HOSTS; j++) begin
                o_ready[j] = (grant_q == GW'(j));
            end
            if (i_ready) begin
                o_read_data = i_read_data;
                o_status    = i_status;
            end else begin
                o_status    = STATUS_SLVERR;
            end
        end
    end

endmodule

// File: tb/tb_rggen_host_arbiter.sv
// Scoreboard bench for rggen_host_arbiter: stimulus queues host transactions
// together with the expected response; a monitor pops and compares on o_ready.
module tb_rggen_host_arbiter;

    localparam int NH = 4;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NH-1:0]      i_request;
    logic [NH*AW-1:0]   i_address;
    logic [NH-1:0]      i_write;
    logic [NH*DW-1:0]   i_write_data;
    logic [NH-1:0]      o_ready;
    logic [DW-1:0]      o_read_data;
    logic [1:0]         o_status;
    logic               o_request;
    logic [AW-1:0]      o_address;
    logic               o_write;
    logic [DW-1:0]      o_write_data;
    logic               i_ready;
    logic [DW-1:0]      i_read_data;
    logic [1:0]         i_status;

    always #5 clk = ~clk;

    rggen_host_arbiter #(
        .NUM_HOSTS      (NH),
        .ADDRESS_WIDTH  (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_request    (i_request),
        .i_address    (i_address),
        .i_write      (i_write),
        .i_write_data (i_write_data),
        .o_ready      (o_ready),
        .o_read_data  (o_read_data),
        .o_status     (o_status),
        .o_request    (o_request),
        .o_address    (o_address),
        .o_write      (o_write),
        .o_write_data (o_write_data),
        .i_ready      (i_ready),
        .i_read_data  (i_read_data),
        .i_status     (i_status)
    );

    typedef struct {
        int          host;
        logic [15:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [1:0]  status;
        int          busy;
    } exp_t;

    typedef struct {
        logic [15:0] addr;
        logic        wr;
        logic [31:0] wdata;
    } txn_t;

    exp_t        exp_q[$];
    txn_t        host_q[NH][$];
    int          n_cmp = 0;
    int          n_bad = 0;

    // slave behaviour knobs; slave_lat < 0 means never ready
    int          slave_lat = 0;
    logic [31:0] slave_rdata = '0;
    logic [1:0]  slave_status = 2'b00;
    logic        force_rdy = 1'b0;
    logic [NH-1:0] done_mask = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit hosts_pending();
        bit p = 1'b0;
        for (int h = 0; h < NH; h++) if (host_q[h].size() != 0) p = 1'b1;
        return p || (i_request != '0);
    endfunction

    task automatic access(input int h, input logic [15:0] a, input logic w, input logic [31:0] wd,
                          input logic [31:0] rd, input logic [1:0] st, input int busy);
        txn_t t;
        exp_t e;
        t.addr = a; t.wr = w; t.wdata = wd;
        host_q[h].push_back(t);
        e.host = h; e.addr = a; e.wr = w; e.wdata = wd; e.rdata = rd; e.status = st; e.busy = busy;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (k < 200 && (exp_q.size() != 0 || o_request || hosts_pending())) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: did not drain, %0d responses still outstanding", name, exp_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic clear_hosts();
        i_request = '0;
        done_mask = '0;
        for (int h = 0; h < NH; h++) host_q[h].delete();
    endtask

    // Slave model: ready after slave_lat BUSY cycles; force_rdy injects stray readies in IDLE.
    initial begin
        int scnt = 0;
        i_ready = 1'b0; i_read_data = '0; i_status = 2'b00;
        forever begin
            @(posedge clk); #1;
            i_read_data = slave_rdata;
            i_status    = slave_status;
            if (!o_request) begin
                scnt    = 0;
                i_ready = force_rdy;
            end else begin
                i_ready = (slave_lat >= 0) && (scnt == slave_lat);
                scnt++;
            end
        end
    end

    // Host drivers: hold request until own o_ready, then load the next queued transaction.
    initial begin
        i_request = '0; i_address = '0; i_write = '0; i_write_data = '0;
        forever begin
            @(posedge clk); #1;
            if (rst_n) begin
                for (int h = 0; h < NH; h++) begin
                    if (done_mask[h]) begin
                        if (host_q[h].size() != 0) void'(host_q[h].pop_front());
                        i_request[h] = 1'b0;
                    end
                    if (!i_request[h] && host_q[h].size() != 0) begin
                        i_address[h*AW +: AW]    = host_q[h][0].addr;
                        i_write[h]               = host_q[h][0].wr;
                        i_write_data[h*DW +: DW] = host_q[h][0].wdata;
                        i_request[h]             = 1'b1;
                    end
                end
            end
            done_mask = '0;
        end
    end

    // Monitor: compares every completion against the scoreboard and checks the IDLE gap.
    initial begin
        int   busy_n = 0;
        logic last_done = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_n    = 0;
                last_done = 1'b0;
            end else begin
                if (last_done) check("idle_gap_request", 64'(o_request), 64'd0);
                last_done = 1'b0;
                if (o_request) busy_n++;
                if (o_ready != '0) begin
                    done_mask = o_ready;
                    last_done = 1'b1;
                    if (exp_q.size() == 0) begin
                        check("unexpected_ready", 64'(o_ready), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("ready_onehot", 64'(o_ready), 64'd1 << e.host);
                        check("read_data",    64'(o_read_data), 64'(e.rdata));
                        check("status",       64'(o_status), 64'(e.status));
                        check("address",      64'(o_address), 64'(e.addr));
                        check("write",        64'(o_write), 64'(e.wr));
                        check("write_data",   64'(o_write_data), 64'(e.wdata));
                        check("busy_cycles",  64'(busy_n), 64'(e.busy));
                    end
                    busy_n = 0;
                end else if (!o_request) begin
                    busy_n = 0;
                end
            end
        end
    end

    initial begin
        txn_t t;
        int   k;
        // reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_request",   64'(o_request), 64'd0);
        check("rst_ready",     64'(o_ready), 64'd0);
        check("rst_status",    64'(o_status), 64'd0);
        check("rst_read_data", 64'(o_read_data), 64'd0);
        check("rst_write",     64'(o_write), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // host0 read, slave ready in the first BUSY cycle
        slave_lat = 0; slave_rdata = 32'hDEADBEEF; slave_status = 2'b00;
        access(0, 16'h0010, 1'b0, 32'h0, 32'hDEADBEEF, 2'b00, 1);
        wait_idle("t1_single_read");

        // hosts 0 and 1 continuously from reset: grants alternate 0,1,0,1
        @(negedge clk); rst_n = 1'b0; clear_hosts();
        repeat (2) @(negedge clk); rst_n = 1'b1;
        slave_lat = 1; slave_rdata = 32'hA5A50001;
        access(0, 16'h0100, 1'b0, 32'h0, 32'hA5A50001, 2'b00, 2);
        access(1, 16'h0104, 1'b0, 32'h0, 32'hA5A50001, 2'b00, 2);
        access(0, 16'h0108, 1'b0, 32'h0, 32'hA5A50001, 2'b00, 2);
        access(1, 16'h010C, 1'b0, 32'h0, 32'hA5A50001, 2'b00, 2);
        wait_idle("t2_alternate");

        // host3 last granted, then hosts 1 and 3: host1 first; then wrap to 0 before 2
        slave_lat = 0; slave_rdata = 32'h00000033;
        access(3, 16'h0300, 1'b0, 32'h0, 32'h00000033, 2'b00, 1);
        wait_idle("t3_prime");
        access(1, 16'h0310, 1'b0, 32'h0, 32'h00000033, 2'b00, 1);
        access(3, 16'h0330, 1'b0, 32'h0, 32'h00000033, 2'b00, 1);
        wait_idle("t3_rr_1_3");
        access(0, 16'h0400, 1'b0, 32'h0, 32'h00000033, 2'b00, 1);
        access(2, 16'h0420, 1'b0, 32'h0, 32'h00000033, 2'b00, 1);
        wait_idle("t3_rr_wrap");

        // host1 write while others idle
        slave_rdata = 32'h0;
        access(1, 16'h0040, 1'b1, 32'h12345678, 32'h0, 2'b00, 1);
        wait_idle("t4_write");

        // timeout on the 8th BUSY cycle, then a normal access, then ready coinciding with expiry
        slave_lat = -1; slave_rdata = 32'h5555AAAA;
        access(2, 16'h0080, 1'b0, 32'h0, 32'h0, 2'b10, 8);
        wait_idle("t5_timeout");
        slave_lat = 0; slave_rdata = 32'h0BADF00D;
        access(3, 16'h00C0, 1'b0, 32'h0, 32'h0BADF00D, 2'b00, 1);
        wait_idle("t5_after_timeout");
        slave_lat = 7; slave_rdata = 32'h600D0007; slave_status = 2'b11;
        access(0, 16'h00E0, 1'b0, 32'h0, 32'h600D0007, 2'b11, 8);
        wait_idle("t5_ready_at_expiry");
        slave_status = 2'b00;

        // stray i_ready while IDLE is ignored
        force_rdy = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_stray_ready", 64'(o_ready), 64'd0);
        end
        force_rdy = 1'b0;
        repeat (2) @(negedge clk);

        // reset mid-BUSY while host1 holds the bus (pointer was 0)
        slave_lat = -1;
        t.addr = 16'h0777; t.wr = 1'b0; t.wdata = 32'h0;
        host_q[1].push_back(t);
        k = 0;
        while (!o_request && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("midbusy_reached_busy", 64'(o_request), 64'd1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midbusy_rst_request", 64'(o_request), 64'd0);
        check("midbusy_rst_ready",   64'(o_ready), 64'd0);
        clear_hosts();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        slave_lat = 0; slave_rdata = 32'h00C0FFEE;
        access(0, 16'h0500, 1'b0, 32'h0, 32'h00C0FFEE, 2'b00, 1);
        access(1, 16'h0510, 1'b0, 32'h0, 32'h00C0FFEE, 2'b00, 1);
        wait_idle("t6_priority_after_reset");

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
